adc_fill_seq: RTL and testbench

Per-run/per-fill sequencer for the ADC fill datapath.
- On run start, issues a stretched initialize pulse to the fill-number counter.
- For each accepted trigger, opens a capture window of a programmed number of ADC samples.
- At the end of each fill, issues exactly one single-cycle increment pulse to the fill-number counter.
- Sits between the trigger/run-control logic and the fill counter plus sample buffer; all in one clock domain.

---
 rtl/adc_fill_seq_if.sv | 32 +++
 rtl/adc_fill_seq.sv | 158 +++++++++++++++
 tb/tb_adc_fill_seq.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_fill_seq_if.sv
// adc_fill_seq_if: run-control, fill-counter and sample-buffer signals of the fill sequencer.
// Latency: none, plain wires; the sequencer registers every output it drives.
// Backpressure: none; every signal is a strobe or a level with no ready.
`timescale 1ns/1ps
interface adc_fill_seq_if #(
    parameter int NSAMP_W   = 16,
    parameter int HOLDOFF_W = 8
);
    logic                 run_start;
    logic                 run_stop;
    logic                 trigger;
    logic [NSAMP_W-1:0]   num_samples;
    logic [HOLDOFF_W-1:0] holdoff_cycles;
    logic                 adc_valid;
    logic                 fill_init;
    logic                 fill_enable;
    logic                 capture_en;
    logic [NSAMP_W-1:0]   sample_idx;
    logic                 run_active;
    logic                 busy;
    logic [15:0]          trig_dropped;

    modport master (
        output run_start, run_stop, trigger, num_samples, holdoff_cycles, adc_valid,
        input  fill_init, fill_enable, capture_en, sample_idx, run_active, busy, trig_dropped
    );

    modport slave (
        input  run_start, run_stop, trigger, num_samples, holdoff_cycles, adc_valid,
        output fill_init, fill_enable, capture_en, sample_idx, run_active, busy, trig_dropped
    );
endinterface

// File: rtl/adc_fill_seq.sv
// adc_fill_seq: per-run/per-fill sequencer; optional post-fill holdoff under ADC_FILL_SEQ_HOLDOFF_EN.
// Latency: outputs registered; capture_en one cycle after an accepted trigger, fill_enable one cycle after the final sample.
// Backpressure: none; triggers arriving during a run but outside ARMED are dropped and counted (saturating).
`timescale 1ns/1ps
module adc_fill_seq #(
    parameter int NSAMP_W      = 16,
    parameter int INIT_STRETCH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    adc_fill_seq_if.slave bus
);
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_INIT    = 3'd1;
    localparam logic [2:0] ST_ARMED   = 3'd2;
    localparam logic [2:0] ST_CAPTURE = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;
    localparam logic [2:0] ST_HOLDOFF = 3'd5;

    // INIT lasts INIT_STRETCH pulse cycles plus 3 cycles for the counter's init synchronizer.
    localparam int INIT_LAST  = INIT_STRETCH + 2;
    localparam int INIT_CNT_W = $clog2(INIT_LAST + 1);

    logic [2:0]            state_q, state_d;
    logic [INIT_CNT_W-1:0] init_cnt_q, init_cnt_d;
    logic [NSAMP_W-1:0]    idx_q, idx_d;
    logic [NSAMP_W-1:0]    nlast_q, nlast_d;
    logic                  stop_q, stop_d;
    logic [15:0]           drop_q, drop_d;
    logic                  fill_init_q, fill_enable_q, capture_en_q, run_active_q, busy_q;
`ifdef ADC_FILL_SEQ_HOLDOFF_EN
    localparam int HOLD_W = $bits(bus.holdoff_cycles);
    logic [HOLD_W-1:0]     hold_q, hold_d;
`endif

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        idx_d      = idx_q;
        nlast_d    = nlast_q;
        stop_d     = stop_q;
        drop_d     = drop_q;
`ifdef ADC_FILL_SEQ_HOLDOFF_EN
        hold_d     = hold_q;
`endif
        if (bus.trigger && state_q != ST_IDLE && state_q != ST_ARMED && drop_q != 16'hFFFF)
            drop_d = drop_q + 16'd1;

        case (state_q)
            ST_IDLE: begin
                if (bus.run_start) begin
                    state_d    = ST_INIT;
                    init_cnt_d = '0;
                    drop_d     = '0;
                end
            end
            ST_INIT: begin
                if (bus.run_stop) stop_d = 1'b1;
                if (init_cnt_q == INIT_CNT_W'(INIT_LAST))
                    state_d = stop_d ? ST_IDLE : ST_ARMED;
                else
                    init_cnt_d = init_cnt_q + 1'b1;
            end
            ST_ARMED: begin
                // A stop in the same cycle as a trigger wins and the trigger is not counted.
                if (bus.run_stop) begin
                    state_d = ST_IDLE;
                end else if (bus.trigger) begin
                    state_d = ST_CAPTURE;
                    idx_d   = '0;
                    nlast_d = (bus.num_samples == '0) ? '0 : bus.num_samples - 1'b1;
`ifdef ADC_FILL_SEQ_HOLDOFF_EN
                    hold_d  = bus.holdoff_cycles;
`endif
                end
            end
            ST_CAPTURE: begin
                if (bus.run_stop) stop_d = 1'b1;
                if (bus.adc_valid) begin
                    if (idx_q == nlast_q) begin
                        state_d = ST_DONE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (bus.run_stop) stop_d = 1'b1;
`ifdef ADC_FILL_SEQ_HOLDOFF_EN
                if (hold_q != '0)
                    state_d = ST_HOLDOFF;
                else
                    state_d = stop_d ? ST_IDLE : ST_ARMED;
`else
                state_d = stop_d ? ST_IDLE : ST_ARMED;
`endif
            end
`ifdef ADC_FILL_SEQ_HOLDOFF_EN
            ST_HOLDOFF: begin
                if (bus.run_stop) stop_d = 1'b1;
                if (hold_q <= HOLD_W'(1))
                    state_d = stop_d ? ST_IDLE : ST_ARMED;
                else
                    hold_d = hold_q - 1'b1;
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_IDLE) stop_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            init_cnt_q    <= '0;
            idx_q         <= '0;
            nlast_q       <= '0;
            stop_q        <= 1'b0;
            drop_q        <= '0;
            fill_init_q   <= 1'b0;
            fill_enable_q <= 1'b0;
            capture_en_q  <= 1'b0;
            run_active_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            init_cnt_q    <= init_cnt_d;
            idx_q         <= idx_d;
            nlast_q       <= nlast_d;
            stop_q        <= stop_d;
            drop_q        <= drop_d;
            // Outputs are decoded from the next state so they line up with the state register.
            fill_init_q   <= (state_d == ST_INIT) && (init_cnt_d < INIT_CNT_W'(INIT_STRETCH));
            fill_enable_q <= (state_d == ST_DONE);
            capture_en_q  <= (state_d == ST_CAPTURE);
            run_active_q  <= (state_d != ST_IDLE);
            busy_q        <= (state_d == ST_INIT) || (state_d == ST_CAPTURE) ||
                             (state_d == ST_DONE) || (state_d == ST_HOLDOFF);
        end
    end

`ifdef ADC_FILL_SEQ_HOLDOFF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hold_q <= '0;
        else        hold_q <= hold_d;
    end
`endif

    assign bus.fill_init    = fill_init_q;
    assign bus.fill_enable  = fill_enable_q;
    assign bus.capture_en   = capture_en_q;
    assign bus.sample_idx   = idx_q;
    assign bus.run_active   = run_active_q;
    assign bus.busy         = busy_q;
    assign bus.trig_dropped = drop_q;
endmodule

// File: tb/tb_adc_fill_seq.sv
// tb_adc_fill_seq: randomized fills against a transaction-level expectation of adc_fill_seq.
// Holdoff expectations follow ADC_FILL_SEQ_HOLDOFF_EN exactly as the design build does.
`timescale 1ns/1ps
module tb_adc_fill_seq;
    localparam int NSAMP_W      = 16;
    localparam int HOLDOFF_W    = 8;
    localparam int INIT_STRETCH = 4;
`ifdef ADC_FILL_SEQ_HOLDOFF_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;

    adc_fill_seq_if #(.NSAMP_W(NSAMP_W), .HOLDOFF_W(HOLDOFF_W)) bus ();

    adc_fill_seq #(.NSAMP_W(NSAMP_W), .INIT_STRETCH(INIT_STRETCH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int exp_drop = 0;
    int exp_fills = 0;
    int fe_cnt = 0;
    int since_init = 1000;
    int viol = 0;

    // fill_enable pulse counter and spacing from the last fill_init cycle
    always @(negedge clk) begin
        if (bus.fill_init === 1'b1) since_init = 0;
        else if (since_init < 1000) since_init = since_init + 1;
        if (bus.fill_enable === 1'b1) begin
            fe_cnt = fe_cnt + 1;
            if (since_init <= 3) viol = viol + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add_drop();
        if (exp_drop < 65535) exp_drop++;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_fill_init"},   bus.fill_init,    0);
        check({tag, "_fill_enable"}, bus.fill_enable,  0);
        check({tag, "_capture_en"},  bus.capture_en,   0);
        check({tag, "_sample_idx"},  bus.sample_idx,   0);
        check({tag, "_run_active"},  bus.run_active,   0);
        check({tag, "_busy"},        bus.busy,         0);
        check({tag, "_trig_drop"},   bus.trig_dropped, 0);
    endtask

    // run_start at t: fill_init over t+1..t+INIT_STRETCH, ARMED at t+INIT_STRETCH+4
    task automatic start_run();
        bus.run_start = 1'b1;
        step();
        bus.run_start = 1'b0;
        exp_drop = 0;
        for (int k = 1; k <= INIT_STRETCH + 3; k++) begin
            check("init_pulse", bus.fill_init, (k <= INIT_STRETCH) ? 1 : 0);
            check("init_busy", bus.busy, 1);
            step();
        end
        check("armed_busy", bus.busy, 0);
        check("armed_run_active", bus.run_active, 1);
        check("armed_drop_clear", bus.trig_dropped, 0);
    endtask

    // One fill from ARMED; triggers on the first cap_trigs strobes and the first hold_trigs holdoff cycles.
    task automatic do_fill(input int n, input int h, input int cap_trigs, input int hold_trigs,
                           input int gap_max, input bit stop_mid);
        int neff, heff, stop_at, gap;
        neff    = (n == 0) ? 1 : n;
        heff    = HOLD_EN ? h : 0;
        stop_at = stop_mid ? $urandom_range(0, neff - 1) : -1;
        bus.num_samples    = n[NSAMP_W-1:0];
        bus.holdoff_cycles = h[HOLDOFF_W-1:0];
        bus.trigger = 1'b1;
        step();
        bus.trigger = 1'b0;
        check("cap_open", bus.capture_en, 1);
        check("idx_start", bus.sample_idx, 0);
        for (int s = 0; s < neff; s++) begin
            gap = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
            for (int g = 0; g < gap; g++) begin
                step();
                check("gap_cap", bus.capture_en, 1);
                check("gap_idx", bus.sample_idx, s);
            end
            bus.adc_valid = 1'b1;
            if (s == stop_at) bus.run_stop = 1'b1;
            if (s < cap_trigs) begin
                bus.trigger = 1'b1;
                add_drop();
            end
            step();
            bus.adc_valid = 1'b0;
            bus.run_stop  = 1'b0;
            bus.trigger   = 1'b0;
            if (s < neff - 1) check("idx_step", bus.sample_idx, s + 1);
        end
        exp_fills++;
        check("done_cap", bus.capture_en, 0);
        check("done_fe", bus.fill_enable, 1);
        check("done_idx", bus.sample_idx, 0);
        for (int k = 0; k < heff; k++) begin
            step();
            bus.trigger = 1'b0;
            check("hold_busy", bus.busy, 1);
            check("hold_fe", bus.fill_enable, 0);
            if (k < hold_trigs) begin
                bus.trigger = 1'b1;
                add_drop();
            end
        end
        step();
        bus.trigger = 1'b0;
        check("after_run_active", bus.run_active, stop_mid ? 0 : 1);
        check("after_busy", bus.busy, 0);
        check("after_fe", bus.fill_enable, 0);
        check("after_drop", bus.trig_dropped, exp_drop);
        check("fill_count", fe_cnt, exp_fills);
    endtask

    initial begin
        int fe_before;
        rst_n = 1'b0;
        bus.run_start = 1'b0;
        bus.run_stop = 1'b0;
        bus.trigger = 1'b0;
        bus.adc_valid = 1'b0;
        bus.num_samples = '0;
        bus.holdoff_cycles = '0;
        repeat (3) step();
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) step();

        // idle: trigger and stop ignored
        bus.trigger = 1'b1;
        bus.run_stop = 1'b1;
        step();
        bus.trigger = 1'b0;
        bus.run_stop = 1'b0;
        check("idle_trig_drop", bus.trig_dropped, 0);
        check("idle_trig_cap", bus.capture_en, 0);
        repeat (5) step();

        start_run();
        do_fill(8, 0, 0, 0, 3, 1'b0);
        do_fill(6, 5, 3, 2, 1, 1'b0);
        check("busy_trig_count", bus.trig_dropped, HOLD_EN ? 5 : 3);

        for (int i = 0; i < 8; i++) begin
            int h;
            h = $urandom_range(0, 6);
            do_fill($urandom_range(0, 12), h, $urandom_range(0, 3), $urandom_range(0, h), 3, 1'b0);
        end
        do_fill(0, 0, 0, 0, 2, 1'b0);
        do_fill(0, 5, 1, 0, 0, 1'b0);

        // stop mid-capture completes the fill, then idle with the count kept
        do_fill(7, 3, 1, 1, 2, 1'b1);
        bus.trigger = 1'b1;
        step();
        bus.trigger = 1'b0;
        check("stopped_trig_drop", bus.trig_dropped, exp_drop);
        check("stopped_cap", bus.capture_en, 0);

        start_run();
        bus.trigger = 1'b1;
        bus.run_stop = 1'b1;
        step();
        bus.trigger = 1'b0;
        bus.run_stop = 1'b0;
        check("trig_stop_active", bus.run_active, 0);
        check("trig_stop_cap", bus.capture_en, 0);
        check("trig_stop_drop", bus.trig_dropped, 0);
        repeat (2) step();
        check("trig_stop_idle_cap", bus.capture_en, 0);

        // saturation across a full-length fill
        start_run();
        do_fill(3, 2, 2, 1, 0, 1'b0);
        do_fill(16'hFFFF, 0, 65535, 0, 0, 1'b0);
        check("sat_value", bus.trig_dropped, 16'hFFFF);
        do_fill(4, 2, 2, 2, 1, 1'b0);
        check("sat_hold", bus.trig_dropped, 16'hFFFF);

        // asynchronous reset mid-capture
        bus.num_samples = 16'd10;
        bus.trigger = 1'b1;
        step();
        bus.trigger = 1'b0;
        for (int s = 0; s < 3; s++) begin
            bus.adc_valid = 1'b1;
            step();
        end
        bus.adc_valid = 1'b0;
        check("abort_idx", bus.sample_idx, 3);
        fe_before = fe_cnt;
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        repeat (3) step();
        check("abort_no_fe", fe_cnt, fe_before);
        rst_n = 1'b1;
        repeat (2) step();
        check_all_zero("abort_release");
        check("abort_no_fe_after", fe_cnt, fe_before);

        start_run();
        do_fill(5, 5, 0, 0, 1, 1'b0);

        check("fe_near_init", viol, 0);
        check("fill_total", fe_cnt, exp_fills);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
        $fatal(1, "timeout");
    end
endmodule
